// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the two-port 6116 RAM arbiter.
package ram_arb_pkg;
    localparam int AW_DEF = 11;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant,
    output logic       valid
);
    always_comb begin
        valid = |eligible;
        grant = eligible[1];
        if (eligible == 2'b11) grant = ~last;
    end
endmodule

// File: rtl/ram_arbiter_6116.sv
// Serialises two requesters onto one synchronous 6116-style RAM; every
// access is IDLE -> ISSUE -> COMPLETE with all outputs registered.
module ram_arbiter_6116
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [1:0][AW-1:0]   addr,
    input  logic [1:0][DW-1:0]   wdata,
    output logic [1:0]           ack,
    output logic [1:0][DW-1:0]   rdata,
    output logic [AW-1:0]        ram_A,
    output logic [DW-1:0]        ram_Din,
    input  logic [DW-1:0]        ram_Dout,
    output logic                 ram_CS_b,
    output logic                 ram_WE_b,
    output logic                 ram_OE_b
);
    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic                wr_q, wr_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0][DW-1:0]  rdata_q, rdata_d;
    logic [AW-1:0]       a_q, a_d;
    logic [DW-1:0]       din_q, din_d;
    logic                cs_q, cs_d, web_q, web_d, oeb_q, oeb_d;

    logic [1:0] eligible;
    logic       gnt, gnt_vld;

    // A port is blind during its own ack cycle so a held req is not re-served.
    assign eligible = req & ~ack_q;

    rr_arb2 u_rr (
        .eligible (eligible),
        .last     (last_q),
        .grant    (gnt),
        .valid    (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        ack_d   = 2'b00;
        rdata_d = rdata_q;
        a_d     = a_q;
        din_d   = din_q;
        cs_d    = 1'b1;
        web_d   = 1'b1;
        oeb_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    // Strobes are loaded here so they are live during ISSUE.
                    last_d  = gnt;
                    win_d   = gnt;
                    wr_d    = we[gnt];
                    a_d     = addr[gnt];
                    din_d   = wdata[gnt];
                    cs_d    = 1'b0;
                    web_d   = ~we[gnt];
                    oeb_d   = we[gnt];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = COMPLETE;
            COMPLETE: begin
                ack_d[win_q] = 1'b1;
                if (!wr_q) rdata_d[win_q] = ram_Dout;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            a_q     <= '0;
            din_q   <= '0;
            cs_q    <= 1'b1;
            web_q   <= 1'b1;
            oeb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            a_q     <= a_d;
            din_q   <= din_d;
            cs_q    <= cs_d;
            web_q   <= web_d;
            oeb_q   <= oeb_d;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign ram_A    = a_q;
    assign ram_Din  = din_q;
    assign ram_CS_b = cs_q;
    assign ram_WE_b = web_q;
    assign ram_OE_b = oeb_q;
endmodule
